// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and requester-id encoding for the register-file write-back path.
package regfile_wb_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_M = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on commit.
module wb_scoreboard #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  clr_valid,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  output logic [NUM_REGS-1:0]   pending
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] set_vec, clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      set_vec[i] = issue_valid && (issue_rd == ADDR_WIDTH'(i));
      clr_vec[i] = clr_valid && (clr_addr == ADDR_WIDTH'(i));
    end
    // A newer issue to the same register outranks the commit of the older write.
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter between ALU and load write-back, with a registered
// register-file write stage and a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_rd,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  m_valid,
  output logic                  m_ready,
  input  logic [ADDR_WIDTH-1:0] m_rd,
  input  logic [DATA_WIDTH-1:0] m_data,
  input  logic                  wb_stall,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  import regfile_wb_arbiter_pkg::*;

  logic                  last_m_q, last_m_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  grant_a, grant_m;
  req_id_e               winner;

  // On contention the side that did not win last time goes first.
  assign grant_a = !wb_stall && a_valid && (!m_valid || last_m_q);
  assign grant_m = !wb_stall && m_valid && (!a_valid || !last_m_q);
  assign winner  = grant_m ? REQ_M : REQ_A;

  assign a_ready = grant_a;
  assign m_ready = grant_m;

  always_comb begin
    last_m_d   = last_m_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_a || grant_m) begin
      last_m_d = (winner == REQ_M);
      if (winner == REQ_M) begin
        rf_waddr_d = m_rd;
        rf_wdata_d = m_data;
      end else begin
        rf_waddr_d = a_rd;
        rf_wdata_d = a_data;
      end
      // Writes to register 0 complete the handshake but are dropped here.
      rf_we_d = (rf_waddr_d != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_m_q   <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      last_m_q   <= last_m_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  wb_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .clr_valid   (rf_we_q),
    .clr_addr    (rf_waddr_q),
    .pending     (pending)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus short random bench for regfile_wb_arbiter with a write scoreboard.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, m_valid, wb_stall, issue_valid;
  logic        a_ready, m_ready, rf_we;
  logic [4:0]  a_rd, m_rd, issue_rd, rf_waddr;
  logic [31:0] a_data, m_data, rf_wdata, pending;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .NUM_REGS   (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_rd        (a_rd),
    .a_data      (a_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_rd        (m_rd),
    .m_data      (m_data),
    .wb_stall    (wb_stall),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .pending     (pending),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pend;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;

  // Reference model state (expected current outputs).
  logic        mdl_last_m = 1'b1;
  logic        cur_we = 1'b0;
  logic [4:0]  cur_waddr = '0;
  logic [31:0] cur_wdata = '0;
  logic [31:0] cur_pend = '0;
  logic        got_a, got_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check readies mid-cycle, predict the edge, compare after it.
  task automatic tick();
    logic  ea, em;
    logic [31:0] setv, clrv;
    exp_t  e, o;
    @(negedge clock);
    ea = !wb_stall && a_valid && (!m_valid || mdl_last_m);
    em = !wb_stall && m_valid && (!a_valid || !mdl_last_m);
    got_a = a_ready;
    got_m = m_ready;
    check("a_ready", {63'b0, a_ready}, {63'b0, ea});
    check("m_ready", {63'b0, m_ready}, {63'b0, em});
    if (reset) begin
      e = '{we: 1'b0, waddr: 5'd0, wdata: 32'd0, pend: 32'd0};
      mdl_last_m = 1'b1;
    end else begin
      setv = issue_valid ? (32'd1 << issue_rd) : 32'd0;
      clrv = cur_we ? (32'd1 << cur_waddr) : 32'd0;
      e.pend = ((cur_pend & ~clrv) | setv) & ~32'd1;
      e.we = 1'b0;
      e.waddr = cur_waddr;
      e.wdata = cur_wdata;
      if (ea) begin
        e.waddr = a_rd; e.wdata = a_data; e.we = (a_rd != 0); mdl_last_m = 1'b0;
      end else if (em) begin
        e.waddr = m_rd; e.wdata = m_data; e.we = (m_rd != 0); mdl_last_m = 1'b1;
      end
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 64'd1, 64'd0);
    end else begin
      o = exp_q.pop_front();
      check("rf_we", {63'b0, rf_we}, {63'b0, o.we});
      check("rf_waddr", {59'b0, rf_waddr}, {59'b0, o.waddr});
      check("rf_wdata", {32'b0, rf_wdata}, {32'b0, o.wdata});
      check("pending", {32'b0, pending}, {32'b0, o.pend});
      cur_we = o.we; cur_waddr = o.waddr; cur_wdata = o.wdata; cur_pend = o.pend;
    end
  endtask

  initial begin
    logic [4:0] seq_addr[4];
    logic       seq_a[4];
    reset = 1'b1; a_valid = 0; m_valid = 0; wb_stall = 0; issue_valid = 0;
    a_rd = '0; m_rd = '0; issue_rd = '0; a_data = '0; m_data = '0;
    tick();
    check("reset_pending", {32'b0, pending}, 64'd0);
    check("reset_we", {63'b0, rf_we}, 64'd0);
    reset = 1'b0;

    // Single uncontended ALU write.
    a_valid = 1; a_rd = 5'd5; a_data = 32'h1234;
    tick();
    check("t1_a_ready", {63'b0, got_a}, 64'd1);
    check("t1_we", {63'b0, rf_we}, 64'd1);
    check("t1_waddr", {59'b0, rf_waddr}, 64'd5);
    check("t1_wdata", {32'b0, rf_wdata}, 64'h1234);
    a_valid = 0;

    // Write to register 0 is accepted but suppressed.
    m_valid = 1; m_rd = 5'd0; m_data = 32'hFFFF;
    tick();
    check("r0_m_ready", {63'b0, got_m}, 64'd1);
    check("r0_we", {63'b0, rf_we}, 64'd0);
    check("r0_pending", {32'b0, pending}, 64'd0);
    m_valid = 0;

    // Continuous contention alternates, starting with A since M won last.
    a_valid = 1; a_rd = 5'd3; a_data = 32'hAAAA;
    m_valid = 1; m_rd = 5'd7; m_data = 32'hBBBB;
    for (int i = 0; i < 4; i++) begin
      tick();
      seq_a[i] = got_a;
      seq_addr[i] = rf_waddr;
      check("rr_we", {63'b0, rf_we}, 64'd1);
    end
    check("rr_g0", {63'b0, seq_a[0]}, 64'd1);
    check("rr_g1", {63'b0, seq_a[1]}, 64'd0);
    check("rr_g2", {63'b0, seq_a[2]}, 64'd1);
    check("rr_g3", {63'b0, seq_a[3]}, 64'd0);
    check("rr_a0", {59'b0, seq_addr[0]}, 64'd3);
    check("rr_a1", {59'b0, seq_addr[1]}, 64'd7);
    check("rr_a2", {59'b0, seq_addr[2]}, 64'd3);
    check("rr_a3", {59'b0, seq_addr[3]}, 64'd7);
    a_valid = 0; m_valid = 0;

    // Scoreboard set then clear at the edge that ends the rf_we cycle.
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    issue_valid = 0;
    check("sb_set", {63'b0, pending[9]}, 64'd1);
    a_valid = 1; a_rd = 5'd9; a_data = 32'h9999;
    tick();
    a_valid = 0;
    check("sb_hold", {63'b0, pending[9]}, 64'd1);
    tick();
    check("sb_clr", {63'b0, pending[9]}, 64'd0);

    // Reissue coinciding with the clear: set wins.
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    issue_valid = 0;
    a_valid = 1; a_data = 32'h5555;
    tick();
    a_valid = 0;
    issue_valid = 1;
    tick();
    issue_valid = 0;
    check("sb_set_wins", {63'b0, pending[9]}, 64'd1);

    // Stall with both valid: nothing granted, pointer held (A won last).
    wb_stall = 1; a_valid = 1; a_rd = 5'd4; a_data = 32'h44; m_valid = 1; m_rd = 5'd6;
    m_data = 32'h66;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ready", {62'b0, got_a, got_m}, 64'd0);
      check("stall_we", {63'b0, rf_we}, 64'd0);
    end
    wb_stall = 0;
    tick();
    check("stall_release_m", {63'b0, got_m}, 64'd1);
    check("stall_release_addr", {59'b0, rf_waddr}, 64'd6);
    a_valid = 0; m_valid = 0;

    // Reset in the cycle after a grant discards the staged write.
    a_valid = 1; a_rd = 5'd12; a_data = 32'hC0DE;
    tick();
    a_valid = 0;
    reset = 1;
    tick();
    check("rst_we", {63'b0, rf_we}, 64'd0);
    check("rst_pending", {32'b0, pending}, 64'd0);
    check("rst_wdata", {32'b0, rf_wdata}, 64'd0);
    reset = 0;
    tick();
    check("rst_after_we", {63'b0, rf_we}, 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      m_valid = 1'($urandom_range(0, 1));
      wb_stall = ($urandom_range(0, 7) == 0);
      issue_valid = 1'($urandom_range(0, 1));
      a_rd = 5'($urandom_range(0, 31));
      m_rd = 5'($urandom_range(0, 31));
      issue_rd = 5'($urandom_range(0, 31));
      a_data = $urandom;
      m_data = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
